// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg -- shared defines and types for the instruction loader.
//
// The macros below are the defines shared across the loader slice:
//   CPU_WIDTH            instruction word width in bits
//   INST_MEM_ADDR_DEPTH  default instruction memory depth in words
//   INST_LOADER_ST_*     FSM state encodings
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds the trailing
// checksum byte (CSUM state).
`ifndef INST_LOADER_DEFINES
`define INST_LOADER_DEFINES
`define CPU_WIDTH 32
`define INST_MEM_ADDR_DEPTH 16
`define INST_LOADER_ST_LEN  3'd0
`define INST_LOADER_ST_DATA 3'd1
`define INST_LOADER_ST_DONE 3'd2
`define INST_LOADER_ST_ERR  3'd3
`define INST_LOADER_ST_CSUM 3'd4
`endif

package inst_loader_pkg;

  localparam int CPU_W = `CPU_WIDTH;

  typedef enum logic [2:0] {
    ST_LEN  = `INST_LOADER_ST_LEN,
    ST_DATA = `INST_LOADER_ST_DATA,
    ST_DONE = `INST_LOADER_ST_DONE,
`ifdef INST_LOADER_CHECKSUM_EN
    ST_CSUM = `INST_LOADER_ST_CSUM,
`endif
    ST_ERR  = `INST_LOADER_ST_ERR
  } state_t;

endpackage

// File: rtl/inst_loader_pack.sv
// inst_loader_pack -- little-endian byte-to-word assembler.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         zero the byte counter (restart of a load)
//   byte_en       a byte is transferred this cycle
//   byte_in       the transferred byte
//   last_byte     combinational: this transfer completes a word
//   word_next     combinational: the word including the current byte
//   word          registered assembled word
//   word_valid    one-cycle pulse the cycle after a word completes
module inst_loader_pack
  import inst_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             byte_en,
  input  logic [7:0]       byte_in,
  output logic             last_byte,
  output logic [CPU_W-1:0] word_next,
  output logic [CPU_W-1:0] word,
  output logic             word_valid
);

  logic [1:0] byte_cnt;

  // Bytes shift in from the top, so after four bytes the first one
  // received sits in bits [7:0] (little-endian).
  assign last_byte = byte_en && (byte_cnt == 2'd3);
  assign word_next = {byte_in, word[CPU_W-1:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_byte && !clear;
      if (clear) begin
        byte_cnt <= 2'd0;
      end else if (byte_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        word     <= word_next;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader -- loads a length-prefixed little-endian byte stream into
// instruction memory and holds the core in reset until it succeeds.
//
// Stream: 4-byte word count N, then N 4-byte words (word k -> address k).
// Optional macro INST_LOADER_CHECKSUM_EN: a trailing byte must equal the
// XOR of all data bytes, otherwise the load is rejected.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready byte-stream handshake, in_data the byte
//   reload            pulse, restarts a load from DONE or ERR
//   mem_we/addr/wdata instruction memory write port
//   core_rst_n        core reset, released only in DONE
//   done, err         load accepted / rejected
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH = `INST_MEM_ADDR_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          reload,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          core_rst_n,
  output logic          done,
  output logic          err
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = ST_CSUM;
`else
  localparam state_t AFTER_DATA = ST_DONE;
`endif

  state_t        state, state_next;
  logic          byte_en, pack_en, reload_go;
  logic          last_byte, word_valid, last_word;
  logic [31:0]   word_next, word;
  logic [AW:0]   len_q, word_cnt;
  logic [AW-1:0] addr_q;
  logic          wr_arm_q;

  assign byte_en   = in_valid && in_ready;
  assign reload_go = reload && ((state == ST_DONE) || (state == ST_ERR));
  assign last_word = ((word_cnt + ONE) == len_q);

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // The checksum byte is consumed by the FSM, not assembled into a word.
  assign pack_en = byte_en && (state != ST_CSUM);

  // Running XOR over data bytes only; the length prefix is excluded.
  always_ff @(posedge clk) begin
    if (rst || reload_go) begin
      csum_q <= 8'd0;
    end else if ((state == ST_DATA) && byte_en) begin
      csum_q <= csum_q ^ in_data;
    end
  end
`else
  assign pack_en = byte_en;
`endif

  inst_loader_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_go),
    .byte_en    (pack_en),
    .byte_in    (in_data),
    .last_byte  (last_byte),
    .word_next  (word_next),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LEN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Decisions are taken on the edge that accepts the
  // completing byte, using the combinationally assembled word, so DONE/ERR
  // is visible the cycle right after the last byte.
  always_comb begin
    state_next = state;
    case (state)
      ST_LEN: begin
        if (last_byte) begin
          if (word_next == 32'd0) begin
            state_next = AFTER_DATA;
          end else if (word_next > DEPTH_W) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (last_byte && last_word) begin
          state_next = AFTER_DATA;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_en) begin
          state_next = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        if (reload) begin
          state_next = ST_LEN;
        end
      end
      default: state_next = ST_LEN;
    endcase
  end

  // Length and word counters. The write strobe comes from the assembler's
  // word_valid pulse, qualified by wr_arm_q which remembers that the word
  // completed while in DATA (length words never reach memory). Since the
  // length is bounded by DEPTH, the word counter never addresses past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      word_cnt <= '0;
      addr_q   <= '0;
      wr_arm_q <= 1'b0;
    end else if (reload_go) begin
      len_q    <= '0;
      word_cnt <= '0;
      wr_arm_q <= 1'b0;
    end else begin
      wr_arm_q <= (state == ST_DATA);
      if ((state == ST_LEN) && last_byte) begin
        len_q <= word_next[AW:0];
      end
      if ((state == ST_DATA) && last_byte) begin
        addr_q   <= word_cnt[AW-1:0];
        word_cnt <= word_cnt + ONE;
      end
    end
  end

  assign in_ready   = (state != ST_DONE) && (state != ST_ERR);
  assign done       = (state == ST_DONE);
  assign err        = (state == ST_ERR);
  assign core_rst_n = (state == ST_DONE);
  assign mem_we     = word_valid && wr_arm_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = word;

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader -- self-checking bench for inst_loader: table of load
// streams plus hand-written reset/reload/gap sequences, with a write
// scoreboard fed at stimulus time and drained by a memory-port monitor.
module tb_inst_loader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          reload;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst_n;
  logic          done;
  logic          err;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    logic [31:0] base;
    logic [31:0] step;
    bit          gap;
    bit          exp_done;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  inst_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .reload     (reload),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one byte at the falling edge and holds it until accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: in_ready stayed %b, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_write(input int k, input logic [31:0] w);
    wr_t e;
    e.addr = AW'(k);
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("reload_done", {31'd0, done}, 32'd0);
    checkOutput("reload_err", {31'd0, err}, 32'd0);
    checkOutput("reload_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    checkOutput("reload_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Sends one complete stream described by a table record and checks the
  // final status the cycle after the last byte.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] w;
    logic [7:0]  xs;
    bit          data_ok;
    xs      = 8'd0;
    data_ok = (v.n <= 32'(DEPTH));
    for (int i = 0; i < 4; i++) send_byte(v.n[8*i +: 8], v.gap);
    if (data_ok) begin
      for (int k = 0; k < int'(v.n); k++) begin
        w = v.base + 32'(k) * v.step;
        push_write(k, w);
        for (int i = 0; i < 4; i++) begin
          xs = xs ^ w[8*i +: 8];
          send_byte(w[8*i +: 8], v.gap);
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      send_byte(xs, v.gap);
`endif
    end
    checkOutput("vec_done", {31'd0, done}, {31'd0, v.exp_done});
    checkOutput("vec_err", {31'd0, err}, {31'd0, !v.exp_done});
    checkOutput("vec_core_rst_n", {31'd0, core_rst_n}, {31'd0, v.exp_done});
    checkOutput("vec_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("vec_writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every write strobe must match the next expected
  // write, and a strobe held longer than one cycle shows up as extra.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: addr %h data %h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("write_addr", {28'd0, mem_addr}, {28'd0, e.addr});
        checkOutput("write_data", mem_wdata, e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{32'd2,          32'h00100513, 32'h00100080, 1'b0, 1'b1};
    vecs[1] = '{32'd0,          32'h0,        32'h0,        1'b0, 1'b1};
    vecs[2] = '{32'(DEPTH + 1), 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[3] = '{32'd1,          32'hDEADBEEF, 32'h0,        1'b1, 1'b1};
    vecs[4] = '{32'(DEPTH),     32'h11223344, 32'h01010101, 1'b0, 1'b1};
    vecs[5] = '{32'd3,          32'hA5A5F00F, 32'h10203041, 1'b1, 1'b1};
    vecs[6] = '{32'h00010001,   32'h0,        32'h0,        1'b0, 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      do_reload();
    end

    // Reset mid-load with a byte in flight: the partial load is abandoned
    // and the next full stream assembles from byte zero.
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_core_rst_n", {31'd0, core_rst_n}, 32'd0);

    // Full N=1 stream; a reload pulse in DATA must be ignored.
    push_write(0, 32'hCAFEF00D);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'hF0, 1'b0);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("reload_ignored_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hCA, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(8'h0D ^ 8'hF0 ^ 8'hFE ^ 8'hCA, 1'b0);
`endif
    checkOutput("newload_done", {31'd0, done}, 32'd1);
    checkOutput("newload_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("newload_drained", 32'(exp_q.size()), 32'd0);
    do_reload();

`ifdef INST_LOADER_CHECKSUM_EN
    // Good and bad checksum on a single-word load.
    for (int pass = 0; pass < 2; pass++) begin
      push_write(0, 32'h00000013);
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h13, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte((pass == 0) ? 8'h13 : 8'h12, 1'b0);
      checkOutput("csum_done", {31'd0, done}, (pass == 0) ? 32'd1 : 32'd0);
      checkOutput("csum_err", {31'd0, err}, (pass == 0) ? 32'd0 : 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("csum_drained", 32'(exp_q.size()), 32'd0);
      do_reload();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter: DEPTH, `INST_MEM_ADDR_DEPTH, instruction memory depth in 32-bit words.
REQ-002 Parameter: AW, $clog2(DEPTH), word-address width.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  byte-stream data valid.
REQ-006 in_ready  output  1  loader accepts byte; transfer on in_valid&&in_ready.
REQ-007 in_data  input  8  stream byte.
REQ-008 reload  input  1  single-cycle pulse; restarts load from DONE or ERR.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  AW  word address.
REQ-011 mem_wdata  output  32  instruction word.
REQ-012 core_rst_n  output  1  core reset, low until load succeeds.
REQ-013 done  output  1  load complete and accepted.
REQ-014 err  output  1  load rejected (length overflow or checksum mismatch).

Function
REQ-015 Stream format SHALL be a 4-byte little-endian word count N, then N words of 4 bytes each, little-endian; word k goes to mem_addr=k.
REQ-016 FSM states SHALL be LEN, DATA, CSUM, DONE, ERR; reset enters LEN.
REQ-017 in_ready SHALL be 1 in LEN, DATA and CSUM, and 0 in DONE and ERR.
REQ-018 LEN: after the 4th byte, N=0 goes to DONE (or CSUM if enabled), N>DEPTH goes to ERR, otherwise DATA.
REQ-019 DATA: the byte counter SHALL wrap 3->0; on the 4th byte, mem_we pulses high for exactly one cycle on the next clock, with mem_addr/mem_wdata valid that cycle.
REQ-020 The word counter SHALL increment per written word; after word N-1 the FSM goes to DONE (or CSUM).
REQ-021 Gaps in in_valid SHALL stall without losing partial byte assembly.
REQ-022 DONE: done=1, core_rst_n=1; ERR: err=1, core_rst_n=0.
REQ-023 reload in DONE or ERR SHALL clear done/err, drive core_rst_n=0, zero the counters and enter LEN next cycle; reload in other states SHALL be ignored.
REQ-024 mem_we SHALL never assert outside DATA-completion cycles; no write at addr>=DEPTH.

Reset
REQ-025 rst SHALL have priority over all inputs, including reload and an in-flight byte.
REQ-026 Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, done=0, err=0, counters=0.
REQ-027 Reset mid-load SHALL abandon the load; words already written are not erased.

Configuration
REQ-028 Macro INST_LOADER_CHECKSUM_EN: when defined, one trailing byte after the data SHALL be compared (in CSUM) with the XOR of all data bytes (length excluded); a match goes to DONE, a mismatch to ERR.
REQ-029 Without INST_LOADER_CHECKSUM_EN, the CSUM state and XOR register SHALL be absent and the last word goes directly to DONE.

Structure
REQ-030 Shared defines file: CPU_WIDTH, INST_MEM_ADDR_DEPTH and FSM state encodings.
REQ-031 One sub-module, inst_loader_pack: the byte-to-word little-endian assembler with byte counter and word_valid pulse.

Verification
REQ-032 N=2, bytes 02 00 00 00 13 05 10 00 93 05 20 00 -> writes addr0=0x00100513, addr1=0x00200593; done=1, core_rst_n=1.
REQ-033 N=0 -> no mem_we; done=1 one cycle after the 4th length byte.
REQ-034 N=DEPTH+1 -> err=1, core_rst_n=0, in_ready=0, no mem_we.
REQ-035 N=1 with in_valid toggling every other cycle -> single correct write; byte assembly is intact.
REQ-036 rst after 6 bytes, then a full N=1 stream -> addr0 holds the new word and done=1; reload in DONE -> done=0 and core_rst_n=0 next cycle.
REQ-037 With CHECKSUM_EN, N=1 word 0x00000013 and checksum 0x13 -> done; checksum 0x12 -> err.
